// File: rtl/tmi_step_counter.sv
// tmi_step_counter: registered up-counter around a ripple chain of 2-bit
// increment-with-carry cells. Each step waits SETTLE_CYCLES clocks for the
// chain to settle, then captures the chain's sum (or wraps to 0 at terminal).

// tmi_inc2: 2-bit increment-with-carry cell, {co, s} = a + ci.
module tmi_inc2 (
    input  logic [1:0] a,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, a} + {2'b00, ci};
endmodule

module tmi_step_counter #(
    parameter int SLICES        = 4,
    parameter int MAX_COUNT     = 255,
    parameter int SETTLE_CYCLES = 10,
    localparam int WIDTH        = 2 * SLICES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step_req,
    output logic             step_ack,
    output logic             tc,
    output logic             busy,
    output logic [WIDTH-1:0] count
);
    // Settle counter must reach SETTLE_CYCLES-1; keep at least one bit.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_VAL     = WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [SW-1:0]   settle_cnt, settle_next;
    logic [WIDTH-1:0] count_next;
    logic            ack_next, tc_next;

    logic [WIDTH-1:0] sum;
    logic [SLICES:0]  carry;
    logic             chain_co;

    // Ripple chain: slice 0 always increments, carries propagate upward.
    assign carry[0] = 1'b1;
    for (genvar i = 0; i < SLICES; i++) begin : g_slice
        tmi_inc2 u_slice (
            .a  (count[2*i+1:2*i]),
            .ci (carry[i]),
            .s  (sum[2*i+1:2*i]),
            .co (carry[i+1])
        );
    end
    assign chain_co = carry[SLICES];

    assign busy = (state != IDLE);

    // Next-state and next-output decode; clr aborts from any state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_next  = state;
        settle_next = settle_cnt;
        count_next  = count;
        ack_next    = 1'b0;
        tc_next     = 1'b0;

        if (clr) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        count_next = load_val;
                    end else if (step_req) begin
                        settle_next = '0;
                        state_next  = WAIT;
                    end
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_next = COMMIT;
                    end else begin
                        settle_next = settle_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    ack_next   = 1'b1;
                    state_next = IDLE;
                    if (count >= MAX_VAL || chain_co) begin
                        count_next = '0;
                        tc_next    = 1'b1;
                    end else begin
                        count_next = sum;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, count and pulse registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            count      <= '0;
            step_ack   <= 1'b0;
            tc         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational block.
            state      <= state_next;
            settle_cnt <= settle_next;
            count      <= count_next;
            step_ack   <= ack_next;
            tc         <= tc_next;
        end
    end
endmodule

// File: tb/tb_tmi_step_counter.sv
// Directed bench for tmi_step_counter: two instances (MAX_COUNT 255 and 200)
// share stimulus; expected values are hand-computed constants.
module tb_tmi_step_counter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, load, step_req;
    logic [7:0] load_val;

    logic       ack_a, tc_a, busy_a;
    logic [7:0] count_a;
    logic       ack_b, tc_b, busy_b;
    logic [7:0] count_b;

    int checks = 0;
    int errors = 0;

    tmi_step_counter u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .step_req(step_req), .step_ack(ack_a), .tc(tc_a), .busy(busy_a),
        .count(count_a)
    );

    tmi_step_counter #(.MAX_COUNT(200)) u_dut_m200 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .step_req(step_req), .step_ack(ack_b), .tc(tc_b), .busy(busy_b),
        .count(count_b)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; load is taken on the following posedge.
    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Called at a negedge. Pulses step_req for one cycle (edge E0), then
    // watches negedges k (k = edges after E0) for the ack. Optional clr or
    // load are applied at negedge clr_at / load_at (taken at edge k+1).
    task automatic run_step(input int clr_at, input int load_at, input logic [7:0] lv,
                            output int ack_k, output int busy_cycles,
                            output logic [7:0] ca, output logic [7:0] cb,
                            output logic ta, output logic tb);
        ack_k = -1;
        busy_cycles = 0;
        ca = '0; cb = '0; ta = 1'b0; tb = 1'b0;
        step_req = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 45; k++) begin
            if (k > 0) @(negedge clk);
            if (ack_a) begin
                ack_k = k;
                ca = count_a; cb = count_b; ta = tc_a; tb = tc_b;
                break;
            end
            if (busy_a) busy_cycles++;
            step_req = 1'b0;
            load     = (k == load_at);
            clr      = (k == clr_at);
            load_val = lv;
        end
        load = 1'b0;
        clr  = 1'b0;
        step_req = 1'b0;
    endtask

    int         k_ack, nbusy;
    logic [7:0] ca, cb;
    logic       ta, tb;
    int         acks[3];
    logic [7:0] cnts[3];
    int         n;
    bit         ack_seen;

    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; step_req = 1'b0; load_val = '0;
        #5;
        check("rst_count", count_a, 0);
        check("rst_busy",  busy_a, 0);
        check("rst_ack",   ack_a, 0);
        check("rst_tc",    tc_a, 0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        // Single step from 0.
        run_step(-1, -1, 8'h00, k_ack, nbusy, ca, cb, ta, tb);
        check("single_lat",   k_ack, 11);
        check("single_busy",  nbusy, 11);
        check("single_count", ca, 1);
        check("single_tc",    ta, 0);
        check("single_idle",  busy_a, 0);
        @(negedge clk);
        check("single_ackpulse", ack_a, 0);

        // Carry ripple across slices.
        do_load(8'h3F);
        check("load_3f", count_a, 8'h3F);
        run_step(-1, -1, 8'h00, k_ack, nbusy, ca, cb, ta, tb);
        check("ripple_40", ca, 8'h40);
        check("ripple_40_tc", ta, 0);
        do_load(8'h7F);
        run_step(-1, -1, 8'h00, k_ack, nbusy, ca, cb, ta, tb);
        check("ripple_80", ca, 8'h80);
        check("ripple_80_m200", cb, 8'h80);

        // Terminal wrap: 200 is terminal for MAX=200 only.
        do_load(8'd200);
        run_step(-1, -1, 8'h00, k_ack, nbusy, ca, cb, ta, tb);
        check("wrap200_a_count", ca, 201);
        check("wrap200_a_tc",    ta, 0);
        check("wrap200_b_count", cb, 0);
        check("wrap200_b_tc",    tb, 1);
        @(negedge clk);
        check("wrap200_tc_pulse", tc_b, 0);
        do_load(8'd250);
        run_step(-1, -1, 8'h00, k_ack, nbusy, ca, cb, ta, tb);
        check("wrap250_a_count", ca, 251);
        check("wrap250_b_count", cb, 0);
        check("wrap250_b_tc",    tb, 1);
        do_load(8'd255);
        run_step(-1, -1, 8'h00, k_ack, nbusy, ca, cb, ta, tb);
        check("wrap255_a_count", ca, 0);
        check("wrap255_a_tc",    ta, 1);
        check("wrap255_b_tc",    tb, 1);

        // Held step_req: three back-to-back steps from 10.
        do_load(8'd10);
        n = 0;
        step_req = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            if (ack_a) begin
                acks[n] = k;
                cnts[n] = count_a;
                n++;
                if (n == 3) break;
            end
        end
        step_req = 1'b0;
        check("held_nacks", n, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("held_lat%0d", i), acks[i], 11 + 12 * i);
            check($sformatf("held_cnt%0d", i), cnts[i], 11 + i);
        end
        @(negedge clk);
        @(negedge clk);
        check("held_stop_busy", busy_a, 0);

        // clr + load together in IDLE: clr wins.
        do_load(8'd9);
        clr = 1'b1; load = 1'b1; load_val = 8'd77;
        @(negedge clk);
        clr = 1'b0; load = 1'b0;
        check("clr_load_count", count_a, 0);

        // load + step_req together in IDLE: load wins, no step.
        load = 1'b1; step_req = 1'b1; load_val = 8'd42;
        @(negedge clk);
        load = 1'b0; step_req = 1'b0;
        check("load_step_count", count_a, 42);
        check("load_step_busy",  busy_a, 0);

        // Load during WAIT is ignored.
        do_load(8'd20);
        run_step(-1, 3, 8'd99, k_ack, nbusy, ca, cb, ta, tb);
        check("waitload_lat",   k_ack, 11);
        check("waitload_count", ca, 21);

        // clr during WAIT aborts the step.
        do_load(8'd30);
        run_step(4, -1, 8'h00, k_ack, nbusy, ca, cb, ta, tb);
        check("abort_noack", k_ack, -1);
        check("abort_busy_cycles", nbusy, 5);
        check("abort_count", count_a, 0);
        check("abort_idle", busy_a, 0);

        // Asynchronous reset mid-WAIT.
        do_load(8'd5);
        check("pre_rst_count", count_a, 5);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy_a, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_count", count_a, 0);
        check("async_rst_busy",  busy_a, 0);
        #1 rst_n = 1'b1;
        ack_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack_a) ack_seen = 1'b1;
        end
        check("post_rst_noack", ack_seen, 0);
        check("post_rst_count", count_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
